// File: rtl/op_share_sched_pkg.sv
// op_sched_pkg: shared types and constants for the operator-sharing scheduler
package op_sched_pkg;

    localparam int OPW_DEF     = 4;
    localparam int TIMEOUT_DEF = 16;

    typedef logic [OPW_DEF-1:0] opcode_t;

    localparam opcode_t OP_ADD = 4'd0;
    localparam opcode_t OP_SUB = 4'd1;
    localparam opcode_t OP_EQ  = 4'd2;
    localparam opcode_t OP_LT  = 4'd3;
    localparam opcode_t OP_AND = 4'd4;
    localparam opcode_t OP_OR  = 4'd5;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

endpackage

// File: rtl/op_share_sched_if.sv
// op_share_sched_if: requester-side request/response bundle for the scheduler
interface op_share_sched_if
    import op_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int OPW   = OPW_DEF
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*OPW-1:0]   req_op;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       rsp_valid;
    logic [NREQ-1:0]       rsp_ready;
    logic [WIDTH-1:0]      rsp_data;
    logic                  rsp_err;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/op_share_sched_arb.sv
// rr_arbiter: combinational rotating-priority picker, search upward from ptr with wrap
module rr_arbiter
    import op_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id
);
    int idx;

    // Scan from farthest to nearest so the requester closest to ptr wins last
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        idx    = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            idx = (idx >= NREQ) ? idx - NREQ : idx;
            if (req[IDW'(idx)]) begin
                gnt    = NREQ'(1) << idx;
                gnt_id = IDW'(idx);
            end
        end
    end
endmodule

// File: rtl/op_share_sched.sv
// op_share_sched: shares one operator between NREQ requesters; optional watchdog via OPSCHED_TIMEOUT_EN
module op_share_sched
    import op_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 32,
    parameter int OPW     = OPW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    op_share_sched_if.slave   bus,
    output logic              op_start,
    output logic [OPW-1:0]    op_code,
    output logic [WIDTH-1:0]  op_a,
    output logic [WIDTH-1:0]  op_b,
    input  logic              op_done,
    input  logic [WIDTH-1:0]  op_result,
    output logic              busy
);
    localparam int IDW = $clog2(NREQ);

    state_t          state, state_n;
    logic [IDW-1:0]  rr_ptr, gnt_id, arb_id;
    logic [NREQ-1:0] arb_gnt;
    logic            xfer, rsp_ack, tmo;

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
        $error("op_share_sched: unsupported NREQ or TIMEOUT");
    end

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req    (bus.req_valid),
        .ptr    (rr_ptr),
        .gnt    (arb_gnt),
        .gnt_id (arb_id)
    );

    assign xfer    = (state == IDLE) && |bus.req_valid;
    assign rsp_ack = bus.rsp_ready[gnt_id];

`ifdef OPSCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wait_cnt;
    logic          err_q;

    assign tmo = (state == WAIT) && !op_done && (wait_cnt == CW'(TIMEOUT - 1));

    // Watchdog counts WAIT cycles (zero on entry) and flags a timed-out response
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
            err_q    <= (state == WAIT && op_done) ? 1'b0 : tmo ? 1'b1 : err_q;
        end
    end
`else
    assign tmo = 1'b0;
`endif

    // State register plus the operand, grant, result and priority-pointer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            gnt_id       <= '0;
            op_code      <= '0;
            op_a         <= '0;
            op_b         <= '0;
            bus.rsp_data <= '0;
        end else begin
            state <= state_n;
            if (xfer) begin
                gnt_id  <= arb_id;
                op_code <= bus.req_op[arb_id*OPW +: OPW];
                op_a    <= bus.req_a[arb_id*WIDTH +: WIDTH];
                op_b    <= bus.req_b[arb_id*WIDTH +: WIDTH];
            end
            if (state == WAIT && op_done)
                bus.rsp_data <= op_result;
            else if (tmo)
                bus.rsp_data <= '0;
            if (state == RESP && rsp_ack)
                rr_ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
        end
    end

    // Next-state logic; op_done only counts while waiting
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (xfer) state_n = ISSUE;
            ISSUE:   state_n = WAIT;
            WAIT:    if (op_done || tmo) state_n = RESP;
            RESP:    if (rsp_ack) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Moore outputs, except req_ready which follows the arbiter in IDLE
    always_comb begin
        bus.req_ready = (state == IDLE) ? arb_gnt : '0;
        bus.rsp_valid = (state == RESP) ? (NREQ'(1) << gnt_id) : '0;
        op_start      = state == ISSUE;
        busy          = state != IDLE;
`ifdef OPSCHED_TIMEOUT_EN
        bus.rsp_err   = err_q;
`else
        bus.rsp_err   = 1'b0;
`endif
    end
endmodule

// File: tb/tb_op_share_sched.sv
// tb_op_share_sched: directed table-driven bench for op_share_sched with a stub operator
module tb_op_share_sched;
    import op_sched_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        op_start, op_done, busy;
    logic [3:0]  op_code;
    logic [31:0] op_a, op_b, op_result;

    always #5 clk = ~clk;

    op_share_sched_if #(.NREQ(4), .WIDTH(32), .OPW(4)) bus ();

    op_share_sched #(.NREQ(4), .WIDTH(32), .OPW(4), .TIMEOUT(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .op_start  (op_start),
        .op_code   (op_code),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_done   (op_done),
        .op_result (op_result),
        .busy      (busy)
    );

    typedef struct {
        logic [3:0]  vmask;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          gnt;
        logic [31:0] res;
        int          hold;
    } vec_t;

    vec_t tbl[12];
    vec_t post;
    int   n_pass = 0;
    int   n_tot  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", nm, act, exp);
    endtask

    function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_EQ:   return {31'b0, a == b};
            OP_LT:   return {31'b0, a < b};
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            default: return 32'h0;
        endcase
    endfunction

    task automatic drive_lanes(input vec_t v);
        for (int i = 0; i < 4; i++) begin
            bus.req_op[i*4 +: 4]  = (i == v.gnt) ? v.op : 4'hF;
            bus.req_a[i*32 +: 32] = (i == v.gnt) ? v.a : (32'hDEAD0000 | 32'(i));
            bus.req_b[i*32 +: 32] = (i == v.gnt) ? v.b : (32'hBEEF0000 | 32'(i));
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [3:0] gm;
        gm = 4'b1 << v.gnt;
        drive_lanes(v);
        bus.req_valid = v.vmask;
        bus.rsp_ready = 4'b0;
        op_done = 1'b0;
        #1;
        chk({tag, " req_ready"}, 32'(bus.req_ready), 32'(gm));
        chk({tag, " busy idle"}, 32'(busy), 32'd0);
        @(negedge clk);
        bus.req_valid = ~gm;
        #1;
        chk({tag, " op_start"}, 32'(op_start), 32'd1);
        chk({tag, " op_code"}, 32'(op_code), 32'(v.op));
        chk({tag, " op_a"}, op_a, v.a);
        chk({tag, " op_b"}, op_b, v.b);
        chk({tag, " busy issue"}, 32'(busy), 32'd1);
        chk({tag, " req_ready issue"}, 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        op_done = 1'b1;
        op_result = alu(op_code, op_a, op_b);
        #1;
        chk({tag, " op_start wait"}, 32'(op_start), 32'd0);
        chk({tag, " rsp_valid wait"}, 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        op_done = 1'b0;
        #1;
        chk({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'(gm));
        chk({tag, " rsp_data"}, bus.rsp_data, v.res);
        chk({tag, " rsp_err"}, 32'(bus.rsp_err), 32'd0);
        chk({tag, " req_ready resp"}, 32'(bus.req_ready), 32'd0);
        for (int c = 0; c < v.hold; c++) begin
            bus.rsp_ready = ~gm;
            @(negedge clk);
            #1;
            chk({tag, " hold rsp_valid"}, 32'(bus.rsp_valid), 32'(gm));
            chk({tag, " hold rsp_data"}, bus.rsp_data, v.res);
            chk({tag, " hold req_ready"}, 32'(bus.req_ready), 32'd0);
            chk({tag, " hold busy"}, 32'(busy), 32'd1);
        end
        bus.rsp_ready = gm;
        @(negedge clk);
        bus.rsp_ready = 4'b0;
        bus.req_valid = 4'b0;
        #1;
        chk({tag, " rsp_valid done"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, " busy done"}, 32'(busy), 32'd0);
        chk({tag, " req_ready done"}, 32'(bus.req_ready), 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " req_ready"}, 32'(bus.req_ready), 32'd0);
        chk({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, " rsp_data"}, bus.rsp_data, 32'd0);
        chk({tag, " rsp_err"}, 32'(bus.rsp_err), 32'd0);
        chk({tag, " op_start"}, 32'(op_start), 32'd0);
        chk({tag, " op_code"}, 32'(op_code), 32'd0);
        chk({tag, " op_a"}, op_a, 32'd0);
        chk({tag, " op_b"}, op_b, 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = '{4'b0001, OP_ADD, 32'd5,        32'd7,        0, 32'd12,       0};
        tbl[1]  = '{4'b1111, OP_SUB, 32'd10,       32'd3,        1, 32'd7,        0};
        tbl[2]  = '{4'b1111, OP_AND, 32'hFF00FF00, 32'h0F0F0F0F, 2, 32'h0F000F00, 0};
        tbl[3]  = '{4'b1111, OP_OR,  32'h000000F0, 32'h00000F00, 3, 32'h00000FF0, 0};
        tbl[4]  = '{4'b1111, OP_EQ,  32'd9,        32'd9,        0, 32'd1,        0};
        tbl[5]  = '{4'b0001, OP_LT,  32'd3,        32'd8,        0, 32'd1,        0};
        tbl[6]  = '{4'b1001, OP_SUB, 32'd0,        32'd1,        3, 32'hFFFFFFFF, 0};
        tbl[7]  = '{4'b0110, OP_ADD, 32'hFFFFFFFF, 32'd1,        1, 32'd0,        0};
        tbl[8]  = '{4'b0100, OP_ADD, 32'd1,        32'd2,        2, 32'd3,        0};
        tbl[9]  = '{4'b1000, OP_LT,  32'd8,        32'd3,        3, 32'd0,        0};
        tbl[10] = '{4'b1010, OP_EQ,  32'd5,        32'd6,        1, 32'd0,        0};
        tbl[11] = '{4'b0010, OP_OR,  32'hA5A5A5A5, 32'h5A5A5A5A, 1, 32'hFFFFFFFF, 5};
        post    = '{4'b1010, OP_ADD, 32'd100,      32'd23,       1, 32'd123,      0};

        bus.req_valid = 4'b0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 4'b0;
        op_done       = 1'b0;
        op_result     = 32'h0;

        repeat (3) @(negedge clk);
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        reset = 1'b0;
        #1;

        for (int i = 0; i < 12; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        drive_lanes('{4'b0100, OP_ADD, 32'd1, 32'd1, 2, 32'd2, 0});
        bus.req_valid = 4'b0100;
        #1;
        chk("rstwait req_ready", 32'(bus.req_ready), 32'h4);
        @(negedge clk);
        bus.req_valid = 4'b0;
        op_done = 1'b1;
        op_result = 32'h00000BAD;
        #1;
        chk("rstwait op_start", 32'(op_start), 32'd1);
        @(negedge clk);
        op_done = 1'b0;
        #1;
        chk("rstwait early done ignored", 32'(bus.rsp_valid), 32'd0);
        chk("rstwait busy", 32'(busy), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rstwait still waiting", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        op_done = 1'b1;
        op_result = 32'h00001234;
        #1;
        chk_reset_vals("after reset");
        @(negedge clk);
        op_done = 1'b0;
        #1;
        chk("late done rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("late done busy", 32'(busy), 32'd0);
        chk("late done rsp_data", bus.rsp_data, 32'd0);

        run_vec(post, "postreset");

`ifdef OPSCHED_TIMEOUT_EN
        begin : timeout_seq
            int k;
            drive_lanes('{4'b0001, OP_ADD, 32'd2, 32'd3, 0, 32'd5, 0});
            bus.req_valid = 4'b0001;
            #1;
            chk("tmo req_ready", 32'(bus.req_ready), 32'h1);
            @(negedge clk);
            bus.req_valid = 4'b0;
            @(negedge clk);
            #1;
            k = 0;
            while (bus.rsp_valid == 4'b0 && k < 40) begin
                @(negedge clk);
                #1;
                k++;
            end
            chk("tmo cycles", 32'(k), 32'd16);
            chk("tmo rsp_valid", 32'(bus.rsp_valid), 32'h1);
            chk("tmo rsp_err", 32'(bus.rsp_err), 32'd1);
            chk("tmo rsp_data", bus.rsp_data, 32'd0);
            op_done = 1'b1;
            op_result = 32'd77;
            @(negedge clk);
            op_done = 1'b0;
            #1;
            chk("tmo late rsp_data", bus.rsp_data, 32'd0);
            chk("tmo late rsp_err", 32'(bus.rsp_err), 32'd1);
            bus.rsp_ready = 4'b0001;
            @(negedge clk);
            bus.rsp_ready = 4'b0;
            #1;
            chk("tmo busy done", 32'(busy), 32'd0);
            chk("tmo rsp_valid done", 32'(bus.rsp_valid), 32'd0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
